// File: rtl/trb_line_packer.sv
// Packs fixed-length 8-bit frames into LINE_BYTES-wide write requests with circular line addressing.
// Optional frame counter enabled by defining TRB_LINE_PACK_STATS_EN.
module trb_line_packer #(
  parameter int LINE_BYTES  = 64,
  parameter int FRAME_BYTES = 128,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              st_data_in,
  input  logic                    st_valid_in,
  input  logic                    st_sop_in,
  input  logic                    st_eop_in,
  output logic                    st_ready_out,
  input  logic                    cfg_start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       buf_lines,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [LINE_BYTES*8-1:0] wr_data,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic                    wr_last,
  output logic [31:0]             frame_cnt,
  output logic                    err_sop,
  output logic                    err_len,
  output logic                    err_ovf
);

  localparam int LW     = LINE_BYTES * 8;
  localparam int LIDX_W = $clog2(LINE_BYTES);
  localparam int BIDX_W = $clog2(FRAME_BYTES);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, PACK} state_e;

  typedef struct packed {
    logic [LW-1:0]     data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } line_t;

  state_e              state_q, state_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d, eidx;
  logic [LIDX_W-1:0]   lane;
  logic [LW-1:0]       asm_q, asm_d, cur_line;
  logic [ADDR_W-1:0]   base_q, size_q, ptr_q, ptr_d;
  logic                push, push_last, fc_inc, sop_err, len_err;
  logic                err_sop_q, err_len_q, err_ovf_q, rdy_q;

  line_t               mem_q [FIFO_DEPTH];
  line_t               head;
  logic [PW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                pop, full, wr_en, ovf;

  // Any sop restarts assembly at byte 0 with a clean line.
  assign eidx = st_sop_in ? '0 : bidx_q;
  assign lane = eidx[LIDX_W-1:0];

  for (genvar k = 0; k < LINE_BYTES; k++) begin : g_lane
    assign cur_line[8*k +: 8] = (lane == LIDX_W'(k)) ? st_data_in :
                                (st_sop_in ? 8'h00 : asm_q[8*k +: 8]);
  end

  always_comb begin
    state_d   = state_q;
    bidx_d    = bidx_q;
    asm_d     = asm_q;
    push      = 1'b0;
    push_last = 1'b0;
    fc_inc    = 1'b0;
    sop_err   = 1'b0;
    len_err   = 1'b0;
    if (cfg_start) begin
      state_d = IDLE;
      bidx_d  = '0;
      asm_d   = '0;
    end else if (st_valid_in) begin
      if (state_q == IDLE && !st_sop_in) begin
        sop_err = 1'b1;
      end else begin
        sop_err = (state_q == PACK) && st_sop_in;
        if (st_eop_in || eidx == BIDX_W'(FRAME_BYTES - 1)) begin
          // Lanes above the current byte are already zero, so early eop pads for free.
          push      = 1'b1;
          push_last = 1'b1;
          fc_inc    = st_eop_in && (eidx == BIDX_W'(FRAME_BYTES - 1));
          len_err   = !fc_inc;
          state_d   = IDLE;
          bidx_d    = '0;
          asm_d     = '0;
        end else begin
          push    = (lane == LIDX_W'(LINE_BYTES - 1));
          asm_d   = push ? '0 : cur_line;
          bidx_d  = eidx + BIDX_W'(1);
          state_d = PACK;
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (cfg_start)
      ptr_d = '0;
    else if (push)
      ptr_d = (ptr_q == size_q - ADDR_W'(1)) ? '0 : ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bidx_q    <= '0;
      asm_q     <= '0;
      ptr_q     <= '0;
      base_q    <= '0;
      size_q    <= '0;
      err_sop_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bidx_q    <= bidx_d;
      asm_q     <= asm_d;
      ptr_q     <= ptr_d;
      err_sop_q <= sop_err;
      err_len_q <= len_err;
      if (cfg_start) begin
        base_q <= base_addr;
        size_q <= buf_lines;
      end
    end
  end

  // Line FIFO: first-word-fall-through; a full FIFO still accepts a push when it pops.
  assign pop   = (cnt_q != '0) && wr_ready;
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign wr_en = push && (!full || pop);
  assign ovf   = push && full && !pop;
  assign cnt_d = cnt_q + CW'(wr_en) - CW'(pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= '{data: cur_line, addr: base_q + ptr_q, last: push_last};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      rdy_q     <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d <= CW'(FIFO_DEPTH - 2));
      if (ovf) err_ovf_q <= 1'b1;
      if (wr_en) wr_q <= (wr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (pop)   rd_q <= (rd_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_q + PW'(1);
    end
  end

  assign wr_valid     = (cnt_q != '0);
  assign head         = wr_valid ? mem_q[rd_q] : '0;
  assign wr_data      = head.data;
  assign wr_addr      = head.addr;
  assign wr_last      = head.last;
  assign st_ready_out = rdy_q;
  assign err_sop      = err_sop_q;
  assign err_len      = err_len_q;
  assign err_ovf      = err_ovf_q;

`ifdef TRB_LINE_PACK_STATS_EN
  logic [31:0] fc_q;
  always_ff @(posedge clk) begin
    if (!rst_n)      fc_q <= '0;
    else if (fc_inc) fc_q <= fc_q + 32'd1;
  end
  assign frame_cnt = fc_q;
`else
  logic unused_fc_inc;
  assign unused_fc_inc = fc_inc;
  assign frame_cnt     = '0;
`endif

endmodule
